alu_ctrl_stage: RTL and testbench
=================================

Name: alu_ctrl_stage

Overview:
Registered, parametrised ALU-control stage at the ID/EX boundary of the pipelined RV32 core. It decodes aluop/funct3/funct7/opcode into the ALU operation code and covers the full RV32I ALU op set, including I-type ALU ops. It registers the result behind a valid/ready handshake with flush support. It also tracks multi-cycle MUL/DIV occupancy and stalls the decode stage while the unit is busy.

Parameters:
CTRL_W, 5, width of alu_ctr; must be >=5 when M_EXT_EN is defined.
MUL_LAT, 3, cycles the EX unit is occupied by a MUL-class op (>=1).
DIV_LAT, 32, cycles the EX unit is occupied by a DIV/REM-class op (>=1).
CNT_W, 6, busy-counter width; must hold max(MUL_LAT,DIV_LAT)-1.

Ports:
clk  in  1  clock; all state updates on its rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  decode fields valid
in_ready  out  1  stage can accept
aluop  in  2  00 add, 01 branch, 10 R-type, 11 I-type ALU
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7 (full field)
opcode  in  7  instruction opcode
flush  in  1  kill held op and abort busy count
out_valid  out  1  alu_ctr valid
out_ready  in  1  EX accepts
alu_ctr  out  CTRL_W  registered ALU op code
illegal  out  1  registered: encoding not supported
busy  out  1  multi-cycle op occupying EX

Behaviour:
- Reset (rst_n=0 at an edge): out_valid=0, alu_ctr=0, illegal=0, busy=0, FSM=IDLE, counter=0. Reset mid-busy aborts immediately.
- Codes (zero-extended to CTRL_W): AND 0000, OR 0001, ADD 0010, SLL 0011, BNE/BLT-compare 0100, XOR 0101, SUB 0110, SLT 0111, SLTU 1000, SRL 1001, JAL 1010, JALR 1011, SRA 1100.
- Decode priority: opcode 1101111 -> JAL; opcode 1100111 -> JALR; otherwise by aluop.
- aluop 00 -> ADD.
- aluop 01 by funct3: 000 SUB, 001 0100, 100 0100, 101 SUB, 110 SLTU, 111 SLTU; others -> AND with illegal=1.
- aluop 10 (funct7 0000000 or 0100000): ADD/SUB (funct7[5] selects SUB), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]), OR, AND. Any other funct7 -> AND with illegal=1, unless M_EXT_EN applies.
- aluop 11: same ops as R-type, with these differences: funct3 000 is always ADD (no SUBI); funct7[5] is honoured only for funct3 101 (SRAI). SLLI/SRLI with funct7 not 0000000 -> illegal.
- Handshake: in_ready = (!out_valid | out_ready) & !busy & !flush. A transfer on in_valid&in_ready loads alu_ctr/illegal and sets out_valid the next cycle, giving 1-cycle latency.
- out_valid&out_ready with no new load -> out_valid=0. alu_ctr holds its last value while out_valid=0.
- Back-to-back single-cycle ops sustain 1 op/cycle.
- FSM IDLE/BUSY:
  - IDLE -> BUSY on downstream acceptance of a MUL-class op with MUL_LAT>1, or a DIV-class op with DIV_LAT>1. Counter loads LAT-1; busy=1 from the next cycle.
  - BUSY: counter decrements each cycle; at counter==1, the next cycle returns to IDLE with busy=0.
  - LAT==1 never enters BUSY.
- flush: next cycle out_valid=0, illegal=0, FSM=IDLE, counter=0, busy=0. Any same-cycle input transfer is dropped. Flush overrides a simultaneous out_ready acceptance, so no busy entry results.
- Simultaneous accept-and-load: the new op replaces the held op in the same edge.

Optional Feature:
M_EXT_EN: when defined, aluop 10 with funct7=0000001 decodes by funct3 to MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011 (MUL-class), and DIV 10100, DIVU 10101, REM 10110, REMU 10111 (DIV-class). Busy tracking is active. When undefined, funct7=0000001 -> AND with illegal=1, busy is tied 0, and no FSM/counter logic is synthesised.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, alu_ctr=0, busy=0, in_ready=1 after release.
- R-type stream: ADD, SUB (funct7 0100000), SRA, AND, back-to-back with out_ready=1 -> alu_ctr 00010, 00110, 01100, 00000 on consecutive cycles, one cycle after each input.
- I-type/jumps: aluop 11 funct3 000 funct7 0100000 -> 00010 (not SUB). opcode 1100111 -> 01011. Branch funct3 010 -> alu_ctr 00000 with illegal=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, alu_ctr stable, no op lost or duplicated after release.
- M_EXT_EN with DIV_LAT=4: DIV accepted at cycle t -> busy=1 cycles t+1..t+3, in_ready=0 there, next op accepted at t+4. MUL with MUL_LAT=1 -> busy never asserts.
- Flush during BUSY of a DIV -> busy=0 and out_valid=0 next cycle; a new ADD is accepted the following cycle and alu_ctr=00010.

Source files
------------

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: ID/EX ALU-control stage. Decodes aluop/funct3/funct7/opcode
// into a registered ALU op code behind a valid/ready handshake with flush.
// Optional macro M_EXT_EN adds RV32M decode plus MUL/DIV busy tracking;
// without it busy is tied low and no FSM/counter is built.
module alu_ctrl_stage #(
   parameter int unsigned CTRL_W  = 5,
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned DIV_LAT = 32,
   parameter int unsigned CNT_W   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        aluop,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [6:0]        opcode,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] alu_ctr,
   output logic              illegal,
   output logic              busy
);

   localparam int unsigned OP_W = 5;

   localparam logic [OP_W-1:0] C_AND  = 5'b00000;
   localparam logic [OP_W-1:0] C_OR   = 5'b00001;
   localparam logic [OP_W-1:0] C_ADD  = 5'b00010;
   localparam logic [OP_W-1:0] C_SLL  = 5'b00011;
   localparam logic [OP_W-1:0] C_BCMP = 5'b00100;
   localparam logic [OP_W-1:0] C_XOR  = 5'b00101;
   localparam logic [OP_W-1:0] C_SUB  = 5'b00110;
   localparam logic [OP_W-1:0] C_SLT  = 5'b00111;
   localparam logic [OP_W-1:0] C_SLTU = 5'b01000;
   localparam logic [OP_W-1:0] C_SRL  = 5'b01001;
   localparam logic [OP_W-1:0] C_JAL  = 5'b01010;
   localparam logic [OP_W-1:0] C_JALR = 5'b01011;
   localparam logic [OP_W-1:0] C_SRA  = 5'b01100;

   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;
   localparam logic [6:0] F7_BASE  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;
`ifdef M_EXT_EN
   localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

   logic [OP_W-1:0]   w_dec_ctr;
   logic              w_dec_ill;
   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_busy;
   logic              r_out_valid;
   logic [CTRL_W-1:0] r_alu_ctr;
   logic              r_illegal;
`ifdef M_EXT_EN
   logic              w_dec_mul;
   logic              w_dec_div;
   logic              r_cls_mul;
   logic              r_cls_div;
`endif

   // Combinational decode of the incoming instruction fields
   always_comb begin
      w_dec_ctr = C_AND;
      w_dec_ill = 1'b0;
`ifdef M_EXT_EN
      w_dec_mul = 1'b0;
      w_dec_div = 1'b0;
`endif
      if (opcode == OPC_JAL) begin
         w_dec_ctr = C_JAL;
      end else if (opcode == OPC_JALR) begin
         w_dec_ctr = C_JALR;
      end else begin
         case (aluop)
            2'b00: w_dec_ctr = C_ADD;
            2'b01: begin
               case (funct3)
                  3'b000:  w_dec_ctr = C_SUB;
                  3'b001:  w_dec_ctr = C_BCMP;
                  3'b100:  w_dec_ctr = C_BCMP;
                  3'b101:  w_dec_ctr = C_SUB;
                  3'b110:  w_dec_ctr = C_SLTU;
                  3'b111:  w_dec_ctr = C_SLTU;
                  default: w_dec_ill = 1'b1;
               endcase
            end
            2'b10: begin
               if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                  case (funct3)
                     3'b000:  w_dec_ctr = funct7[5] ? C_SUB : C_ADD;
                     3'b001:  w_dec_ctr = C_SLL;
                     3'b010:  w_dec_ctr = C_SLT;
                     3'b011:  w_dec_ctr = C_SLTU;
                     3'b100:  w_dec_ctr = C_XOR;
                     3'b101:  w_dec_ctr = funct7[5] ? C_SRA : C_SRL;
                     3'b110:  w_dec_ctr = C_OR;
                     default: w_dec_ctr = C_AND;
                  endcase
               end
`ifdef M_EXT_EN
               else if (funct7 == F7_MULDIV) begin
                  w_dec_ctr = {2'b10, funct3};
                  w_dec_mul = ~funct3[2];
                  w_dec_div = funct3[2];
               end
`endif
               else begin
                  w_dec_ill = 1'b1;
               end
            end
            default: begin
               // I-type: no SUBI; funct7 only meaningful for shifts
               case (funct3)
                  3'b000:  w_dec_ctr = C_ADD;
                  3'b001: begin
                     if (funct7 == F7_BASE) w_dec_ctr = C_SLL;
                     else                   w_dec_ill = 1'b1;
                  end
                  3'b010:  w_dec_ctr = C_SLT;
                  3'b011:  w_dec_ctr = C_SLTU;
                  3'b100:  w_dec_ctr = C_XOR;
                  3'b101: begin
                     if (funct7 == F7_ALT)       w_dec_ctr = C_SRA;
                     else if (funct7 == F7_BASE) w_dec_ctr = C_SRL;
                     else                        w_dec_ill = 1'b1;
                  end
                  3'b110:  w_dec_ctr = C_OR;
                  default: w_dec_ctr = C_AND;
               endcase
            end
         endcase
      end
   end

   assign in_ready   = (~r_out_valid | out_ready) & ~w_busy & ~flush;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   // Output register: flush kills, new load replaces, acceptance drains
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_alu_ctr   <= '0;
         r_illegal   <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (w_in_fire) begin
         r_out_valid <= 1'b1;
         r_alu_ctr   <= CTRL_W'(w_dec_ctr);
         r_illegal   <= w_dec_ill;
      end else if (w_out_fire) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef M_EXT_EN
   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Class of the held op, consulted when EX accepts it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cls_mul <= 1'b0;
         r_cls_div <= 1'b0;
      end else if (w_in_fire) begin
         r_cls_mul <= w_dec_mul;
         r_cls_div <= w_dec_div;
      end
   end

   // Busy FSM state and occupancy counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Busy FSM next state: enter on EX acceptance of a multi-cycle op
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (flush) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_out_fire && r_cls_mul && (MUL_LAT > 1)) begin
                  w_state_nxt = S_BUSY;
                  w_cnt_nxt   = CNT_W'(MUL_LAT - 1);
               end else if (w_out_fire && r_cls_div && (DIV_LAT > 1)) begin
                  w_state_nxt = S_BUSY;
                  w_cnt_nxt   = CNT_W'(DIV_LAT - 1);
               end
            end
            default: begin
               if (r_cnt <= CNT_W'(1)) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign w_busy = (r_state == S_BUSY);
`else
   logic [CNT_W-1:0] w_unused_lat;

   assign w_busy       = 1'b0;
   assign w_unused_lat = CNT_W'(MUL_LAT) ^ CNT_W'(DIV_LAT);
`endif

   assign out_valid = r_out_valid;
   assign alu_ctr   = r_alu_ctr;
   assign illegal   = r_illegal;
   assign busy      = w_busy;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb_alu_ctrl_stage: directed-vector bench for alu_ctrl_stage.
// Exercises the M_EXT_EN busy paths only when that macro is defined.
module tb_alu_ctrl_stage;

   localparam int unsigned CTRL_W = 5;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        aluop;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [6:0]        opcode;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] alu_ctr;
   logic              illegal;
   logic              busy;

   int n_checks;
   int n_errors;
   logic [CTRL_W-1:0] acc_q[$];

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_I    = 7'b0010011;
   localparam logic [6:0] OPC_B    = 7'b1100011;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;

   alu_ctrl_stage #(
      .CTRL_W (CTRL_W),
      .MUL_LAT(1),
      .DIV_LAT(4),
      .CNT_W  (6)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .aluop    (aluop),
      .funct3   (funct3),
      .funct7   (funct7),
      .opcode   (opcode),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .alu_ctr  (alu_ctr),
      .illegal  (illegal),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every op EX actually takes
   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) acc_q.push_back(alu_ctr);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [6:0] opc);
      in_valid = 1'b1;
      aluop    = op;
      funct3   = f3;
      funct7   = f7;
      opcode   = opc;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(2'b10, 3'b000, 7'h00, OPC_R);

      // Reset held two cycles with in_valid asserted
      step();
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu_ctr",   alu_ctr,   0);
      chk("rst_illegal",   illegal,   0);
      chk("rst_busy",      busy,      0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);

      // R-type back-to-back stream
      drive(2'b10, 3'b000, 7'h00, OPC_R); step();
      chk("r_add", alu_ctr, 5'b00010); chk("r_add_v", out_valid, 1);
      drive(2'b10, 3'b000, 7'h20, OPC_R); step();
      chk("r_sub", alu_ctr, 5'b00110); chk("r_sub_v", out_valid, 1);
      drive(2'b10, 3'b101, 7'h20, OPC_R); step();
      chk("r_sra", alu_ctr, 5'b01100);
      drive(2'b10, 3'b111, 7'h00, OPC_R); step();
      chk("r_and", alu_ctr, 5'b00000); chk("r_and_ill", illegal, 0);
      in_valid = 1'b0; step();
      chk("r_drain_v", out_valid, 0); chk("r_drain_hold", alu_ctr, 5'b00000);

      // I-type, jumps and branches
      drive(2'b11, 3'b000, 7'h20, OPC_I); step();
      chk("i_addi_nosub", alu_ctr, 5'b00010); chk("i_addi_ill", illegal, 0);
      drive(2'b11, 3'b101, 7'h20, OPC_I); step();
      chk("i_srai", alu_ctr, 5'b01100);
      drive(2'b11, 3'b001, 7'h20, OPC_I); step();
      chk("i_slli_bad", alu_ctr, 5'b00000); chk("i_slli_bad_ill", illegal, 1);
      drive(2'b00, 3'b000, 7'h00, OPC_JALR); step();
      chk("jalr", alu_ctr, 5'b01011); chk("jalr_ill", illegal, 0);
      drive(2'b00, 3'b000, 7'h00, OPC_JAL); step();
      chk("jal", alu_ctr, 5'b01010);
      drive(2'b01, 3'b001, 7'h00, OPC_B); step();
      chk("br_bne", alu_ctr, 5'b00100);
      drive(2'b01, 3'b010, 7'h00, OPC_B); step();
      chk("br_bad", alu_ctr, 5'b00000); chk("br_bad_ill", illegal, 1);
      drive(2'b10, 3'b000, 7'h01, OPC_R); step();
`ifdef M_EXT_EN
      chk("m_mul_code", alu_ctr, 5'b10000); chk("m_mul_ill", illegal, 0);
`else
      chk("nom_muldiv", alu_ctr, 5'b00000); chk("nom_muldiv_ill", illegal, 1);
`endif
      in_valid = 1'b0; step();
      chk("nobusy_lat1", busy, 0);
      step();
      chk("nobusy_lat1_b", busy, 0);

      // Backpressure: hold XOR while OR waits
      acc_q.delete();
      out_ready = 1'b0;
      drive(2'b10, 3'b100, 7'h00, OPC_R); step();
      chk("bp_first", alu_ctr, 5'b00101);
      drive(2'b10, 3'b110, 7'h00, OPC_R);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", in_ready, 0);
         step();
         chk("bp_hold", alu_ctr, 5'b00101);
         chk("bp_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", in_ready, 1);
      step();
      chk("bp_second", alu_ctr, 5'b00001);
      in_valid = 1'b0; step();
      chk("bp_drained", out_valid, 0);
      chk("bp_acc_n", acc_q.size(), 2);
      if (acc_q.size() == 2) begin
         chk("bp_acc0", acc_q[0], 5'b00101);
         chk("bp_acc1", acc_q[1], 5'b00001);
      end

      // Flush kills a held illegal op and drops same-cycle input
      out_ready = 1'b0;
      drive(2'b01, 3'b011, 7'h00, OPC_B); step();
      chk("fl_pre_ill", illegal, 1);
      drive(2'b00, 3'b000, 7'h00, OPC_R);
      flush = 1'b1;
      #1;
      chk("fl_in_ready", in_ready, 0);
      step();
      chk("fl_valid", out_valid, 0); chk("fl_ill", illegal, 0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
      chk("fl_no_load", out_valid, 0);

`ifdef M_EXT_EN
      // DIV with latency 4: busy for three cycles after EX accepts it
      drive(2'b10, 3'b100, 7'h01, OPC_R); step();
      chk("div_code", alu_ctr, 5'b10100); chk("div_busy_pre", busy, 0);
      in_valid = 1'b0; step();
      chk("div_busy_t1", busy, 1);
      drive(2'b00, 3'b000, 7'h00, OPC_R);
      #1;
      chk("div_rdy_t1", in_ready, 0);
      step();
      chk("div_busy_t2", busy, 1); chk("div_noload_t2", out_valid, 0);
      step();
      chk("div_busy_t3", busy, 1); chk("div_rdy_t3", in_ready, 0);
      step();
      chk("div_busy_t4", busy, 0); chk("div_rdy_t4", in_ready, 1);
      step();
      chk("div_next_v", out_valid, 1); chk("div_next_add", alu_ctr, 5'b00010);
      in_valid = 1'b0; step();

      // Flush mid-busy, then a fresh ADD
      drive(2'b10, 3'b110, 7'h01, OPC_R); step();
      chk("rem_code", alu_ctr, 5'b10110);
      in_valid = 1'b0; step(); step();
      chk("fb_busy", busy, 1);
      drive(2'b00, 3'b000, 7'h00, OPC_R);
      flush = 1'b1; step();
      chk("fb_busy_clr", busy, 0); chk("fb_valid_clr", out_valid, 0);
      flush = 1'b0;
      #1;
      chk("fb_rdy", in_ready, 1);
      step();
      chk("fb_add_v", out_valid, 1); chk("fb_add", alu_ctr, 5'b00010);
      in_valid = 1'b0; step();
      chk("fb_busy_after", busy, 0);
`else
      chk("nom_busy", busy, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
